// File: rtl/trigger_ring_seq_pkg.sv
// trigger_ring_seq_pkg: state encodings and strobe levels shared by the ring sequencer.
package trigger_ring_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_GATE  = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_WAIT  = 3'd5
  } state_t;
  localparam logic STB_ON  = 1'b1;
  localparam logic STB_OFF = 1'b0;
endpackage

// File: rtl/ring_step_timer.sv
// ring_step_timer: loadable down-counter that saturates at zero and flags it.
module ring_step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? val : (cnt != '0) ? cnt - 1'b1 : cnt;
  assign zero = (cnt == '0);
endmodule

// File: rtl/trigger_ring_seq.sv
// trigger_ring_seq: trigger-ring step sequencer; define RING_CHECK_EN to enable the ring feedback check.
module trigger_ring_seq
  import trigger_ring_seq_pkg::*;
#(
  parameter int N          = 8,
  parameter int GATE_SETUP = 2,
  parameter int PULSE_W    = 1,
  parameter int STEP_PER   = 16,
  parameter int CLR_W      = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_single,
  input  logic                 i_clear,
  input  logic [N-1:0]         i_ring,
  output logic [N-1:0]         o_set_gate,
  output logic [N-1:0]         o_ac_set,
  output logic [N-1:0]         o_reset_gate,
  output logic [N-1:0]         o_ac_reset,
  output logic [N-1:0]         o_dc_set_n,
  output logic [N-1:0]         o_dc_reset_n,
  output logic [$clog2(N)-1:0] o_stage,
  output logic                 o_step,
  output logic                 o_busy,
  output logic                 o_err
);
  localparam int SW = $clog2(N);
  localparam int TW = $clog2(STEP_PER + 1);
  localparam int WAIT_L = STEP_PER - GATE_SETUP - PULSE_W - 2;
  localparam logic [N-1:0] DC_SET_N = ~N'(1);
  localparam logic [N-1:0] DC_RST_N = N'(1);
  state_t state, ns;
  logic [SW-1:0] nx;
  logic [N-1:0] cur_oh, nx_oh;
  logic [TW-1:0] t_val;
  logic t_zero, mis, stop_pend, one_shot, act;
  assign nx = (o_stage == SW'(N - 1)) ? '0 : o_stage + 1'b1;
  assign cur_oh = N'(1) << o_stage;
  assign nx_oh = N'(1) << nx;
  assign act = ns inside {S_GATE, S_PULSE, S_HOLD};
  assign t_val = (ns == S_GATE)  ? TW'(GATE_SETUP - 1) :
                 (ns == S_PULSE) ? TW'(PULSE_W - 1) :
                 (ns == S_WAIT)  ? TW'(WAIT_L) :
                 (ns == S_CLEAR) ? TW'(CLR_W - 1) : '0;
  // Every phase reloads the shared timer on entry and leaves when it reaches zero.
  ring_step_timer #(.W(TW)) u_timer (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .load (ns != state),
    .val  (t_val),
    .zero (t_zero)
  );
`ifdef RING_CHECK_EN
  assign mis = (state == S_WAIT) & t_zero & (i_ring != cur_oh);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_err <= 1'b0;
    else o_err <= (ns == S_CLEAR) ? 1'b0 : o_err | mis;
`else
  logic unused_ring;
  assign unused_ring = ^i_ring;
  assign mis = 1'b0;
  assign o_err = 1'b0;
`endif
  always_comb begin
    ns = state;
    case (state)
      S_IDLE:  ns = i_clear ? S_CLEAR : (i_start | i_single) ? S_GATE : S_IDLE;
      S_CLEAR: ns = t_zero ? S_IDLE : S_CLEAR;
      S_GATE:  ns = t_zero ? S_PULSE : S_GATE;
      S_PULSE: ns = t_zero ? S_HOLD : S_PULSE;
      S_HOLD:  ns = S_WAIT;
      S_WAIT:  ns = !t_zero ? S_WAIT :
                    (i_start & ~stop_pend & ~i_stop & ~one_shot & ~mis) ? S_GATE : S_IDLE;
      default: ns = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so strobes line up with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_stage      <= '0;
      o_set_gate   <= '0;
      o_reset_gate <= '0;
      o_ac_set     <= '0;
      o_ac_reset   <= '0;
      o_dc_set_n   <= DC_SET_N;
      o_dc_reset_n <= DC_RST_N;
      o_step       <= STB_OFF;
      o_busy       <= 1'b0;
      stop_pend    <= 1'b0;
      one_shot     <= 1'b0;
    end else begin
      state        <= ns;
      o_stage      <= (state == S_HOLD) ? nx : (ns == S_CLEAR) ? '0 : o_stage;
      o_set_gate   <= act ? nx_oh : '0;
      o_reset_gate <= act ? cur_oh : '0;
      o_ac_set     <= (ns == S_PULSE) ? nx_oh : '0;
      o_ac_reset   <= (ns == S_PULSE) ? cur_oh : '0;
      o_dc_set_n   <= (ns == S_CLEAR) ? DC_SET_N : '1;
      o_dc_reset_n <= (ns == S_CLEAR) ? DC_RST_N : '1;
      o_step       <= (ns == S_WAIT && state != S_WAIT) ? STB_ON : STB_OFF;
      o_busy       <= (ns != S_IDLE);
      stop_pend    <= (ns == S_IDLE) ? 1'b0 : stop_pend | i_stop;
      one_shot     <= (ns == S_IDLE) ? 1'b0 : one_shot | (state == S_IDLE & i_single);
    end
endmodule

// File: tb/tb_trigger_ring_seq.sv
// tb_trigger_ring_seq: directed bench driving trigger_ring_seq against a trigger2 ring model.
module tb_trigger_ring_seq;
  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, single = 1'b0, clear = 1'b0, force_zero = 1'b0;
  logic [7:0] ring = 8'h00;
  logic [7:0] ring_in;
  logic [7:0] set_gate, ac_set, reset_gate, ac_reset, dc_set_n, dc_reset_n;
  logic [2:0] stage;
  logic step, busy, err;
  int n_chk = 0, n_fail = 0;
  assign ring_in = force_zero ? 8'h00 : ring;
  trigger_ring_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_single(single),
    .i_clear(clear), .i_ring(ring_in), .o_set_gate(set_gate), .o_ac_set(ac_set),
    .o_reset_gate(reset_gate), .o_ac_reset(ac_reset), .o_dc_set_n(dc_set_n),
    .o_dc_reset_n(dc_reset_n), .o_stage(stage), .o_step(step), .o_busy(busy), .o_err(err)
  );
  always #5 clk = ~clk;
  // trigger2 ring: DC forces dominate, then gated AC set/reset.
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      ring[i] <= !dc_set_n[i] ? 1'b1 : !dc_reset_n[i] ? 1'b0 :
                 (ac_set[i] & set_gate[i]) ? 1'b1 : (ac_reset[i] & reset_gate[i]) ? 1'b0 : ring[i];
  // {set_gate, reset_gate, ac_set, ac_reset, step, busy, stage} at cycle c of a step from stage cur
  function automatic logic [36:0] exp_vec(int c, int cur);
    logic [7:0] one;
    logic [7:0] cg, ng;
    int nxt;
    nxt = (cur + 1) % 8;
    one = 8'h01;
    cg = one << cur;
    ng = one << nxt;
    return {(c < 4) ? ng : 8'h00, (c < 4) ? cg : 8'h00, (c == 2) ? ng : 8'h00,
            (c == 2) ? cg : 8'h00, c == 4, 1'b1, (c < 4) ? 3'(cur) : 3'(nxt)};
  endfunction
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (dc_set_n !== 8'hFE) begin n_fail++; $display("FAIL reset_dc_set_n got=%h exp=fe", dc_set_n); end
    n_chk++; if (dc_reset_n !== 8'h01) begin n_fail++; $display("FAIL reset_dc_reset_n got=%h exp=01", dc_reset_n); end
    n_chk++; if (ring !== 8'h01) begin n_fail++; $display("FAIL reset_ring got=%h exp=01", ring); end
    n_chk++; if ({busy, step, err, stage} !== 6'h00) begin n_fail++; $display("FAIL reset_status got=%b exp=000000", {busy, step, err, stage}); end
    n_chk++; if ((set_gate | reset_gate | ac_set | ac_reset) !== 8'h00) begin n_fail++; $display("FAIL reset_strobes got=%h exp=00", set_gate | reset_gate | ac_set | ac_reset); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({dc_set_n, dc_reset_n} !== 16'hFFFF) begin n_fail++; $display("FAIL release_dc got=%h exp=ffff", {dc_set_n, dc_reset_n}); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy got=%b exp=0", busy); end
  endtask
  task automatic test_single();
    logic [36:0] e;
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    for (int c = 0; c < 16; c++) begin
      e = exp_vec(c, 0);
      n_chk++; if ({set_gate, reset_gate, ac_set, ac_reset, step, busy, stage} !== e) begin
        n_fail++; $display("FAIL single_c%0d got=%h exp=%h", c, {set_gate, reset_gate, ac_set, ac_reset, step, busy, stage}, e);
      end
      @(negedge clk);
    end
    n_chk++; if ({busy, stage} !== 4'b0001) begin n_fail++; $display("FAIL single_idle got=%b exp=0001", {busy, stage}); end
    n_chk++; if (ring !== 8'h02) begin n_fail++; $display("FAIL single_ring got=%h exp=02", ring); end
  endtask
  task automatic test_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_chk++; if ({dc_set_n, dc_reset_n, busy} !== {16'hFE01, 1'b1}) begin
        n_fail++; $display("FAIL clear_dc_c%0d got=%h exp=%h", c, {dc_set_n, dc_reset_n, busy}, {16'hFE01, 1'b1});
      end
      @(negedge clk);
    end
    n_chk++; if ({dc_set_n, dc_reset_n} !== 16'hFFFF) begin n_fail++; $display("FAIL clear_dc_end got=%h exp=ffff", {dc_set_n, dc_reset_n}); end
    n_chk++; if ({busy, err, stage} !== 5'b00000) begin n_fail++; $display("FAIL clear_status got=%b exp=00000", {busy, err, stage}); end
    n_chk++; if (ring !== 8'h01) begin n_fail++; $display("FAIL clear_ring got=%h exp=01", ring); end
  endtask
  task automatic test_run();
    logic [36:0] e;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 16; c++) begin
        e = exp_vec(c, k);
        n_chk++; if ({set_gate, reset_gate, ac_set, ac_reset, step, busy, stage} !== e) begin
          n_fail++; $display("FAIL run_k%0d_c%0d got=%h exp=%h", k, c, {set_gate, reset_gate, ac_set, ac_reset, step, busy, stage}, e);
        end
        if (k == 7 && c == 5) start = 1'b0;
        @(negedge clk);
      end
    n_chk++; if ({busy, stage} !== 4'b0000) begin n_fail++; $display("FAIL run_end got=%b exp=0000", {busy, stage}); end
    n_chk++; if (ring !== 8'h01) begin n_fail++; $display("FAIL run_ring got=%h exp=01", ring); end
  endtask
  task automatic test_stop();
    logic [36:0] e;
    int gates;
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 48; c++) begin
      e = exp_vec(c % 16, c / 16);
      n_chk++; if ({set_gate, reset_gate, ac_set, ac_reset, step, busy, stage} !== e) begin
        n_fail++; $display("FAIL stop_c%0d got=%h exp=%h", c, {set_gate, reset_gate, ac_set, ac_reset, step, busy, stage}, e);
      end
      stop = (c == 32);
      @(negedge clk);
    end
    n_chk++; if ({busy, stage} !== 4'b0011) begin n_fail++; $display("FAIL stop_idle got=%b exp=0011", {busy, stage}); end
    start = 1'b0;
    gates = 0;
    repeat (20) begin
      @(negedge clk);
      if (set_gate !== 8'h00 || busy !== 1'b0) gates++;
    end
    n_chk++; if (gates !== 0) begin n_fail++; $display("FAIL stop_quiet got=%0d exp=0", gates); end
  endtask
  task automatic test_back_to_back();
    logic [36:0] e;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int c = 0; c < 16; c++) begin
      e = exp_vec(c, 3);
      n_chk++; if ({set_gate, reset_gate, ac_set, ac_reset, step, busy, stage} !== e) begin
        n_fail++; $display("FAIL startstop_c%0d got=%h exp=%h", c, {set_gate, reset_gate, ac_set, ac_reset, step, busy, stage}, e);
      end
      @(negedge clk);
    end
    n_chk++; if ({busy, stage} !== 4'b0100) begin n_fail++; $display("FAIL startstop_idle got=%b exp=0100", {busy, stage}); end
    start = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL startstop_stay got=%b exp=0", busy); end
  endtask
  task automatic test_ring_err();
    logic [36:0] e;
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      e = exp_vec(c, 4);
      n_chk++; if ({set_gate, reset_gate, ac_set, ac_reset, step, busy, stage} !== e) begin
        n_fail++; $display("FAIL ringerr_c%0d got=%h exp=%h", c, {set_gate, reset_gate, ac_set, ac_reset, step, busy, stage}, e);
      end
      if (c == 8) force_zero = 1'b1;
      @(negedge clk);
    end
`ifdef RING_CHECK_EN
    n_chk++; if ({err, busy, stage} !== 5'b10101) begin n_fail++; $display("FAIL ringerr_trip got=%b exp=10101", {err, busy, stage}); end
    start = 1'b0;
    force_zero = 1'b0;
    @(negedge clk);
    n_chk++; if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL ringerr_sticky got=%b exp=10", {err, busy}); end
`else
    n_chk++; if ({err, busy, stage} !== 5'b01101) begin n_fail++; $display("FAIL ringerr_ignored got=%b exp=01101", {err, busy, stage}); end
    start = 1'b0;
    force_zero = 1'b0;
    repeat (16) @(negedge clk);
    n_chk++; if ({err, busy, stage} !== 5'b00110) begin n_fail++; $display("FAIL ringerr_done got=%b exp=00110", {err, busy, stage}); end
`endif
  endtask
  task automatic test_reset_mid();
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({ac_set, ac_reset} !== 16'h0201) begin n_fail++; $display("FAIL mid_pulse got=%h exp=0201", {ac_set, ac_reset}); end
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    n_chk++; if ({set_gate, reset_gate, ac_set, ac_reset} !== 32'h0) begin
      n_fail++; $display("FAIL mid_drop got=%h exp=00000000", {set_gate, reset_gate, ac_set, ac_reset});
    end
    n_chk++; if ({dc_set_n, dc_reset_n, busy} !== {16'hFE01, 1'b0}) begin
      n_fail++; $display("FAIL mid_dc got=%h exp=%h", {dc_set_n, dc_reset_n, busy}, {16'hFE01, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ring !== 8'h01) begin n_fail++; $display("FAIL mid_ring got=%h exp=01", ring); end
    n_chk++; if ({busy, stage, dc_set_n} !== {4'b0000, 8'hFF}) begin
      n_fail++; $display("FAIL mid_after got=%h exp=%h", {busy, stage, dc_set_n}, {4'b0000, 8'hFF});
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_clear();
    test_run();
    test_stop();
    test_back_to_back();
    test_ring_err();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
